fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the
// instruction memory (slave). A request is held while imem_req=1; the
// memory answers with imem_ack and imem_rdata in the cycle the word is valid.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, issues instruction-memory reads and feeds the decode stage.
// Load-use stalls (cu_wpcir) park the fetched word in a hold buffer.
// Taken branches (cu_branch) redirect the PC and insert a bubble into IF/ID.
// Build option: define FETCH_IMEM_WAIT_EN to honour imem_ack.
// This enables the WAIT and DROP states for multi-cycle memories.
// With the macro undefined, every request completes in its own cycle.
module fetch_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                cu_wpcir,
  input  logic                cu_branch,
  input  logic [31:0]         branch_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         if_instr,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc4,
  output logic                fetch_busy
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] id_instr_reg, id_instr_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic [31:0] hold_buf_reg, hold_buf_next;
  logic        req_int;
  logic [31:0] if_instr_int;
  logic        ack_eff;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

`ifdef FETCH_IMEM_WAIT_EN
  assign ack_eff = imem.imem_ack;
`else
  // Single-cycle memory: every request is answered immediately.
  logic unused_ack;
  assign unused_ack = imem.imem_ack;
  assign ack_eff    = 1'b1;
`endif

  // 32-bit add wraps 0xFFFFFFFC -> 0 on its own.
  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = {branch_target[31:2], 2'b00};

  // Next-state, PC and IF/ID update; branch always wins over a stall.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    id_instr_next = id_instr_reg;
    id_pc4_next   = id_pc4_reg;
    hold_buf_next = hold_buf_reg;
    req_int       = 1'b0;
    if_instr_int  = 32'd0;
    case (state_reg)
      S_FETCH, S_WAIT: begin
        req_int = 1'b1;
        if (ack_eff) begin
          if_instr_int = imem.imem_rdata;
        end
        if (cu_branch) begin
          pc_next       = target_aligned;
          id_instr_next = 32'd0;
          // An unanswered request must be drained before refetching,
          // so its late word is not taken as the branch target's word.
          state_next    = ack_eff ? S_FETCH : S_DROP;
        end else if (ack_eff) begin
          if (cu_wpcir) begin
            hold_buf_next = imem.imem_rdata;
            state_next    = S_HOLD;
          end else begin
            id_instr_next = imem.imem_rdata;
            id_pc4_next   = pc_plus4;
            pc_next       = pc_plus4;
            state_next    = S_FETCH;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      S_HOLD: begin
        if_instr_int = hold_buf_reg;
        if (cu_branch) begin
          pc_next       = target_aligned;
          id_instr_next = 32'd0;
          state_next    = S_FETCH;
        end else if (!cu_wpcir) begin
          id_instr_next = hold_buf_reg;
          id_pc4_next   = pc_plus4;
          pc_next       = pc_plus4;
          state_next    = S_FETCH;
        end
      end
      S_DROP: begin
        if (cu_branch) begin
          pc_next       = target_aligned;
          id_instr_next = 32'd0;
        end
        if (ack_eff) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_FETCH;
      pc_reg       <= 32'd0;
      id_instr_reg <= 32'd0;
      id_pc4_reg   <= 32'd0;
      hold_buf_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      id_instr_reg <= id_instr_next;
      id_pc4_reg   <= id_pc4_next;
      hold_buf_reg <= hold_buf_next;
    end
  end

  // Request and presented word are suppressed while reset is held.
  assign imem.imem_req  = req_int & rst;
  assign imem.imem_addr = pc_reg;
  assign if_instr       = rst ? if_instr_int : 32'd0;
  assign id_instr       = id_instr_reg;
  assign id_pc4         = id_pc4_reg;

`ifdef FETCH_IMEM_WAIT_EN
  assign fetch_busy = (state_reg == S_WAIT) || (state_reg == S_DROP);
`else
  assign fetch_busy = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each stimulus row pushes the outputs
// expected in that cycle; a monitor pops and compares them mid-cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cu_wpcir = 1'b0;
  logic        cu_branch = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        ack_drv = 1'b1;
  logic [31:0] if_instr, id_instr, id_pc4;
  logic        fetch_busy;

  fetch_unit_if bus ();

  // Memory returns an address-tagged word so every word is distinguishable.
  assign bus.imem_ack   = ack_drv;
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .cu_wpcir      (cu_wpcir),
    .cu_branch     (cu_branch),
    .branch_target (branch_target),
    .imem          (bus),
    .if_instr      (if_instr),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .fetch_busy    (fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          row;
    logic        req;
    logic [31:0] addr;
    logic [31:0] id;
    logic [31:0] pc4;
    logic        busy;
    logic [31:0] ifi;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   row_cnt      = 0;

  function automatic logic [31:0] w(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Apply one cycle of inputs just after the rising edge and queue the
  // outputs expected for the remainder of that cycle.
  task automatic step(input logic r, input logic wp, input logic br,
                      input logic [31:0] tgt, input logic ack,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic [31:0] e_id, input logic [31:0] e_pc4,
                      input logic e_busy, input logic [31:0] e_if);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    cu_wpcir      = wp;
    cu_branch     = br;
    branch_target = tgt;
    ack_drv       = ack;
    e.row  = row_cnt;
    e.req  = e_req;
    e.addr = e_addr;
    e.id   = e_id;
    e.pc4  = e_pc4;
    e.busy = e_busy;
    e.ifi  = e_if;
    exp_q.push_back(e);
    row_cnt++;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (bus.imem_req !== e.req || bus.imem_addr !== e.addr ||
            id_instr !== e.id || id_pc4 !== e.pc4 ||
            fetch_busy !== e.busy || if_instr !== e.ifi) begin
          tests_failed++;
          $display("[TB] FAIL row%0d got req=%b addr=%h id=%h pc4=%h busy=%b if=%h want req=%b addr=%h id=%h pc4=%h busy=%b if=%h",
                   e.row, bus.imem_req, bus.imem_addr, id_instr, id_pc4, fetch_busy, if_instr,
                   e.req, e.addr, e.id, e.pc4, e.busy, e.ifi);
        end else begin
          $display("[TB] row%0d ok req=%b addr=%h id=%h pc4=%h busy=%b if=%h",
                   e.row, bus.imem_req, bus.imem_addr, id_instr, id_pc4, fetch_busy, if_instr);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //    rst wp br target         ack  req addr           id                  pc4            busy if
    step(0, 0, 0, 32'h0,        1,   0, 32'h0,         32'h0,              32'h0,         0, 32'h0);
    step(1, 0, 0, 32'h0,        1,   1, 32'h0,         32'h0,              32'h0,         0, w(32'h0));
    step(1, 0, 0, 32'h0,        1,   1, 32'h4,         w(32'h0),           32'h4,         0, w(32'h4));
    step(1, 0, 0, 32'h0,        1,   1, 32'h8,         w(32'h4),           32'h8,         0, w(32'h8));
    step(1, 0, 0, 32'h0,        1,   1, 32'hC,         w(32'h8),           32'hC,         0, w(32'hC));
    // load-use stall for two cycles at pc=0x10
    step(1, 1, 0, 32'h0,        1,   1, 32'h10,        w(32'hC),           32'h10,        0, w(32'h10));
    step(1, 1, 0, 32'h0,        1,   0, 32'h10,        w(32'hC),           32'h10,        0, w(32'h10));
    step(1, 0, 0, 32'h0,        1,   0, 32'h10,        w(32'hC),           32'h10,        0, w(32'h10));
    step(1, 0, 0, 32'h0,        1,   1, 32'h14,        w(32'h10),          32'h14,        0, w(32'h14));
    // branch with misaligned target bits to reach pc=0x8
    step(1, 0, 1, 32'h0B,       1,   1, 32'h18,        w(32'h14),          32'h18,        0, w(32'h18));
    // branch at pc=0x8 to 0x40: word from 0x8 must never reach IF/ID
    step(1, 0, 1, 32'h40,       1,   1, 32'h8,         32'h0,              32'h18,        0, w(32'h8));
    // branch and stall together: branch wins
    step(1, 1, 1, 32'h63,       1,   1, 32'h40,        32'h0,              32'h18,        0, w(32'h40));
    step(1, 0, 0, 32'h0,        1,   1, 32'h60,        32'h0,              32'h18,        0, w(32'h60));
    // stall into HOLD, then branch out of HOLD discarding the buffer
    step(1, 1, 0, 32'h0,        1,   1, 32'h64,        w(32'h60),          32'h64,        0, w(32'h64));
    step(1, 1, 1, 32'h20,       1,   0, 32'h64,        w(32'h60),          32'h64,        0, w(32'h64));
    step(1, 0, 0, 32'h0,        1,   1, 32'h20,        32'h0,              32'h64,        0, w(32'h20));
    // PC wrap at the top of the address space
    step(1, 0, 1, 32'hFFFFFFFC, 1,   1, 32'h24,        w(32'h20),          32'h24,        0, w(32'h24));
    step(1, 0, 0, 32'h0,        1,   1, 32'hFFFFFFFC,  32'h0,              32'h24,        0, w(32'hFFFFFFFC));
    step(1, 0, 0, 32'h0,        1,   1, 32'h0,         w(32'hFFFFFFFC),    32'h0,         0, w(32'h0));
    // asynchronous reset mid-cycle, then restart from address 0
    step(0, 0, 0, 32'h0,        1,   0, 32'h0,         32'h0,              32'h0,         0, 32'h0);
    step(1, 0, 0, 32'h0,        1,   1, 32'h0,         32'h0,              32'h0,         0, w(32'h0));
    step(1, 0, 0, 32'h0,        1,   1, 32'h4,         w(32'h0),           32'h4,         0, w(32'h4));
`ifdef FETCH_IMEM_WAIT_EN
    // delayed ack, branch in first wait cycle -> DROP until ack
    step(1, 0, 0, 32'h0,        0,   1, 32'h8,         w(32'h4),           32'h8,         0, 32'h0);
    step(1, 0, 1, 32'h40,       0,   1, 32'h8,         w(32'h4),           32'h8,         1, 32'h0);
    step(1, 0, 0, 32'h0,        0,   0, 32'h40,        32'h0,              32'h8,         1, 32'h0);
    step(1, 0, 0, 32'h0,        1,   0, 32'h40,        32'h0,              32'h8,         1, 32'h0);
    step(1, 0, 0, 32'h0,        1,   1, 32'h40,        32'h0,              32'h8,         0, w(32'h40));
    // reach WAIT at pc=0x20, then reset mid-wait
    step(1, 0, 1, 32'h20,       1,   1, 32'h44,        w(32'h40),          32'h44,        0, w(32'h44));
    step(1, 0, 0, 32'h0,        0,   1, 32'h20,        32'h0,              32'h44,        0, 32'h0);
    step(1, 0, 0, 32'h0,        0,   1, 32'h20,        32'h0,              32'h44,        1, 32'h0);
    step(0, 0, 0, 32'h0,        0,   0, 32'h0,         32'h0,              32'h0,         0, 32'h0);
    step(1, 0, 0, 32'h0,        0,   1, 32'h0,         32'h0,              32'h0,         0, 32'h0);
    // stale ack after reset is taken as the word for address 0
    step(1, 0, 0, 32'h0,        1,   1, 32'h0,         32'h0,              32'h0,         1, w(32'h0));
    step(1, 0, 0, 32'h0,        1,   1, 32'h4,         w(32'h0),           32'h4,         0, w(32'h4));
`endif
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
